// File: rtl/aes_pkg.sv
// Shared types and constants for the AES SPI framing front-end.
package aes_pkg;

    typedef enum logic [1:0] {
        KS128 = 2'b00,
        KS192 = 2'b01,
        KS256 = 2'b10
    } ksize_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        START,
        WAIT,
        OUT
    } frame_state_t;

    localparam int HDR_W      = 8;
    localparam int BLOCK_W    = 128;
    localparam int HDR_KS_MSB = 7;
    localparam int HDR_KS_LSB = 6;
    localparam int HDR_KEEP   = 1;
    localparam int HDR_DEC    = 0;

    function automatic logic [8:0] klen(input ksize_t ks);
        case (ks)
            KS192:   klen = 9'd192;
            KS256:   klen = 9'd256;
            default: klen = 9'd128;
        endcase
    endfunction

endpackage

// File: rtl/aes_spi_frame_if.sv
// Core-side bus between the SPI framer (master) and the encrypt/decrypt core (slave).
interface aes_spi_frame_if #(
    parameter int KMAX = 256
);
    import aes_pkg::*;

    // core_start is a one-cycle pulse; core_decrypt/ksize/key/block are valid
    // with it and hold until the next frame completes. The core answers with a
    // one-cycle core_valid pulse, core_result being valid only in that cycle.
    logic              core_start;
    logic              core_decrypt;
    ksize_t            core_ksize;
    logic [KMAX-1:0]   core_key;
    logic [BLOCK_W-1:0] core_block;
    logic [BLOCK_W-1:0] core_result;
    logic              core_valid;

    modport master (
        output core_start, core_decrypt, core_ksize, core_key, core_block,
        input  core_result, core_valid
    );

    modport slave (
        input  core_start, core_decrypt, core_ksize, core_key, core_block,
        output core_result, core_valid
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/aes_spi_frame.sv
// SPI-slave framing front-end: shifts in header, block and key, runs the core
// once over the start/valid handshake, then shifts the 128-bit result out on sdo.
module aes_spi_frame
    import aes_pkg::*;
#(
    parameter int KMAX        = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sck,
    input  logic            sdi,
    input  logic            load,
    output logic            sdo,
    output logic            done,
    output logic            err,
    aes_spi_frame_if.master core,
    output frame_state_t    dbg_state
);
    localparam logic [8:0] BASE_LEN = 9'(HDR_W + BLOCK_W);
    localparam logic [8:0] OUT_LEN  = 9'(BLOCK_W);
    localparam logic [8:0] KMAX_LEN = 9'(KMAX);

    logic sck_rise, sck_fall, sdi_s, load_rise, load_fall;
    logic sck_level_unused, sdi_rise_unused, sdi_fall_unused, load_level_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d_i(sck),
        .q_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset_n(reset_n), .d_i(sdi),
        .q_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .reset_n(reset_n), .d_i(load),
        .q_o(load_level_unused), .rise_o(load_rise), .fall_o(load_fall)
    );

    frame_state_t        state_q;
    logic [8:0]          bit_cnt_q;
    logic [6:0]          hdr_q;
    logic                keep_q, hdr_dec_q;
    ksize_t              hdr_ks_q;
    logic [8:0]          frame_len_q;
    logic [BLOCK_W-1:0]  block_sh_q;
    logic [KMAX-2:0]     key_sh_q;
    logic                key_valid_q;
    logic                start_q, dec_q;
    ksize_t              ks_q;
    logic [KMAX-1:0]     key_q;
    logic [BLOCK_W-1:0]  block_q, result_q;
    logic                done_q, err_q;

    logic [8:0]          cnt_d;
    logic [7:0]          hdr_d;
    ksize_t              hdr_ks;
    logic                hdr_bad;
    logic [8:0]          hdr_len;
    logic [BLOCK_W-1:0]  block_d;
    logic [KMAX-1:0]     key_d, key_just;
    logic [8:0]          key_shift;

    assign cnt_d   = bit_cnt_q + 9'd1;
    assign hdr_d   = {hdr_q, sdi_s};
    assign hdr_ks  = ksize_t'(hdr_d[HDR_KS_MSB:HDR_KS_LSB]);
    // A retained-key header ignores its ksize field, so only the stored-key flag matters.
    assign hdr_bad = hdr_d[HDR_KEEP] ? !key_valid_q
                   : ((hdr_d[HDR_KS_MSB:HDR_KS_LSB] == 2'b11) ||
                      ({1'b0, klen(hdr_ks)} > 10'(KMAX)));
    assign hdr_len = hdr_d[HDR_KEEP] ? BASE_LEN : BASE_LEN + klen(hdr_ks);

    assign block_d   = {block_sh_q[BLOCK_W-2:0], sdi_s};
    assign key_d     = {key_sh_q, sdi_s};
    // Only the last K shifted bits are key; left-justify them and zero the tail.
    assign key_shift = KMAX_LEN - klen(hdr_ks_q);
    assign key_just  = key_d << key_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            hdr_q       <= '0;
            keep_q      <= 1'b0;
            hdr_dec_q   <= 1'b0;
            hdr_ks_q    <= KS128;
            frame_len_q <= '0;
            block_sh_q  <= '0;
            key_sh_q    <= '0;
            key_valid_q <= 1'b0;
            start_q     <= 1'b0;
            dec_q       <= 1'b0;
            ks_q        <= KS128;
            key_q       <= '0;
            block_q     <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_rise) begin
                        bit_cnt_q <= '0;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (load_fall) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        hdr_q     <= hdr_d[6:0];
                        bit_cnt_q <= cnt_d;
                        if (cnt_d == 9'(HDR_W)) begin
                            if (hdr_bad) begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                err_q       <= 1'b0;
                                keep_q      <= hdr_d[HDR_KEEP];
                                hdr_dec_q   <= hdr_d[HDR_DEC];
                                hdr_ks_q    <= hdr_ks;
                                frame_len_q <= hdr_len;
                                state_q     <= BODY;
                            end
                        end
                    end
                end
                BODY: begin
                    if (load_fall) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt_q <= cnt_d;
                        if (bit_cnt_q < BASE_LEN) block_sh_q <= block_d;
                        else                      key_sh_q   <= key_d[KMAX-2:0];
                        if (cnt_d == frame_len_q) begin
                            block_q <= keep_q ? block_d : block_sh_q;
                            dec_q   <= hdr_dec_q;
                            if (!keep_q) begin
                                key_q       <= key_just;
                                ks_q        <= hdr_ks_q;
                                key_valid_q <= 1'b1;
                            end
                            start_q <= 1'b1;
                            state_q <= START;
                        end
                    end
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (load_rise) err_q <= 1'b1;
                    if (core.core_valid) begin
                        result_q  <= core.core_result;
                        done_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (load_rise) begin
                        done_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= HDR;
                    end else if (sck_fall) begin
                        result_q  <= result_q << 1;
                        bit_cnt_q <= cnt_d;
                        if (cnt_d == OUT_LEN) begin
                            done_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdo               = done_q & result_q[BLOCK_W-1];
    assign done              = done_q;
    assign err               = err_q;
    assign dbg_state         = state_q;
    assign core.core_start   = start_q;
    assign core.core_decrypt = dec_q;
    assign core.core_ksize   = ks_q;
    assign core.core_key     = key_q;
    assign core.core_block   = block_q;

endmodule

// File: tb/tb_aes_spi_frame.sv
// Directed bench for aes_spi_frame using FIPS-197 C.1/C.3 vectors and a queue scoreboard.
module tb_aes_spi_frame;
    import aes_pkg::*;

    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128L = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct packed {
        logic [255:0] key;
        logic [127:0] blk;
        logic [1:0]   ks;
        logic         dec;
    } start_t;

    logic clk = 1'b0, reset_n = 1'b1;
    logic sck = 1'b0, sdi = 1'b0, load = 1'b0, load192 = 1'b0;
    logic sdo, done, err, sdo192, done192, err192;
    frame_state_t dbg_state, dbg_state192;

    int total = 0;
    int bad = 0;
    int start192 = 0;

    start_t       exp_start_q[$];
    logic [127:0] exp_q[$];

    aes_spi_frame_if #(.KMAX(256)) bus ();
    aes_spi_frame_if #(.KMAX(192)) bus192 ();

    aes_spi_frame #(.KMAX(256), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .done(done), .err(err), .core(bus), .dbg_state(dbg_state)
    );

    aes_spi_frame #(.KMAX(192), .SYNC_STAGES(2)) dut192 (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load192),
        .sdo(sdo192), .done(done192), .err(err192), .core(bus192), .dbg_state(dbg_state192)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, bound 3000000 exceeded");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [391:0] mkframe(input logic [7:0] hdr, input logic [127:0] blk,
                                             input logic [255:0] key);
        return {hdr, blk, key};
    endfunction

    // ---------------- driver ----------------
    task automatic spi_send(input logic [391:0] frame, input int nbits, input bit to192);
        @(negedge clk);
        if (to192) load192 = 1'b1; else load = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = frame[391 - i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
        #40 sdi = 1'b0;
        #80;
        if (to192) load192 = 1'b0; else load = 1'b0;
        #80;
    endtask

    task automatic read_bits(input int nbits, output logic [127:0] r);
        int t;
        t = 0;
        r = '0;
        @(negedge clk);
        while (done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_rise", 256'(done), 256'(1'b1));
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            #20 r = {r[126:0], sdo};
            #20 sck = 1'b0;
            #40;
        end
    endtask

    task automatic read_full(input string name);
        logic [127:0] r;
        logic [127:0] e;
        read_bits(128, r);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got result %h required none queued", name, r);
        end else begin
            e = exp_q.pop_front();
            check(name, 256'(r), 256'(e));
        end
        #40;
        check({name, "_done_low"}, 256'(done), 256'(1'b0));
        check({name, "_state_idle"}, 256'(dbg_state), 256'(IDLE));
    endtask

    // ---------------- core model ----------------
    initial begin
        bus.core_valid     = 1'b0;
        bus.core_result    = '0;
        bus192.core_valid  = 1'b0;
        bus192.core_result = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                repeat (20) @(negedge clk);
                if (bus.core_decrypt && bus.core_ksize == KS256 && bus.core_key == K256 &&
                    bus.core_block == C3_CT)
                    bus.core_result = PT;
                else if (!bus.core_decrypt && bus.core_ksize == KS128 && bus.core_key == K128L &&
                         bus.core_block == PT)
                    bus.core_result = C1_CT;
                else
                    bus.core_result = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
                bus.core_valid = 1'b1;
                @(negedge clk);
                bus.core_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        start_t s;
        forever begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                if (exp_start_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got core_start=1 required 0");
                end else begin
                    s = exp_start_q.pop_front();
                    check("start_key", bus.core_key, s.key);
                    check("start_block", 256'(bus.core_block), 256'(s.blk));
                    check("start_ksize", 256'(bus.core_ksize), 256'(s.ks));
                    check("start_decrypt", 256'(bus.core_decrypt), 256'(s.dec));
                end
            end
            if (bus192.core_start === 1'b1) start192++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] r;
        logic [127:0] c1_tmp;

        #1 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_sdo", 256'(sdo), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_start", 256'(bus.core_start), 256'(0));
        check("rst_decrypt", 256'(bus.core_decrypt), 256'(0));
        check("rst_ksize", 256'(bus.core_ksize), 256'(0));
        check("rst_key", bus.core_key, 256'(0));
        check("rst_block", 256'(bus.core_block), 256'(0));
        check("rst_state", 256'(dbg_state), 256'(IDLE));
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // KEEP_KEY with nothing stored
        spi_send(mkframe(8'h02, 128'h0, 256'h0), 8, 1'b0);
        check("keep_nokey_err", 256'(err), 256'(1));
        check("keep_nokey_state", 256'(dbg_state), 256'(IDLE));

        // 256-bit key on a 192-bit build
        spi_send(mkframe(8'h80, PT, K256), 8, 1'b1);
        check("k192_err", 256'(err192), 256'(1));
        check("k192_state", 256'(dbg_state192), 256'(IDLE));

        // C.3 256-bit decrypt
        exp_start_q.push_back('{key: K256, blk: C3_CT, ks: 2'b10, dec: 1'b1});
        exp_q.push_back(PT);
        spi_send(mkframe(8'h81, C3_CT, K256), 392, 1'b0);
        read_full("c3_result");
        check("c3_err", 256'(err), 256'(0));
        check("c3_ksize_hold", 256'(bus.core_ksize), 256'(2'b10));
        check("c3_decrypt_hold", 256'(bus.core_decrypt), 256'(1));

        // C.1 128-bit encrypt
        exp_start_q.push_back('{key: K128L, blk: PT, ks: 2'b00, dec: 1'b0});
        exp_q.push_back(C1_CT);
        spi_send(mkframe(8'h00, PT, K128L), 264, 1'b0);
        read_full("c1_result");
        check("c1_err", 256'(err), 256'(0));
        check("c1_key_hold", bus.core_key, K128L);

        // retained key, 136-bit frame
        exp_start_q.push_back('{key: K128L, blk: PT, ks: 2'b00, dec: 1'b0});
        exp_q.push_back(C1_CT);
        spi_send(mkframe(8'h02, PT, 256'h0), 136, 1'b0);
        read_full("keep_result");
        check("keep_err", 256'(err), 256'(0));

        // abort after 50 bits, then a clean frame
        spi_send(mkframe(8'h81, C3_CT, K256), 50, 1'b0);
        check("abort_err", 256'(err), 256'(1));
        check("abort_state", 256'(dbg_state), 256'(IDLE));
        exp_start_q.push_back('{key: K256, blk: C3_CT, ks: 2'b10, dec: 1'b1});
        exp_q.push_back(PT);
        spi_send(mkframe(8'h81, C3_CT, K256), 392, 1'b0);
        read_full("post_abort_result");
        check("post_abort_err", 256'(err), 256'(0));

        // reset during readout
        exp_start_q.push_back('{key: K128L, blk: PT, ks: 2'b00, dec: 1'b0});
        spi_send(mkframe(8'h00, PT, K128L), 264, 1'b0);
        read_bits(40, r);
        c1_tmp = C1_CT;
        check("partial_40", 256'(r[39:0]), 256'(c1_tmp[127:88]));
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("midrst_done", 256'(done), 256'(0));
        check("midrst_sdo", 256'(sdo), 256'(0));
        check("midrst_err", 256'(err), 256'(0));
        check("midrst_start", 256'(bus.core_start), 256'(0));
        check("midrst_state", 256'(dbg_state), 256'(IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_send(mkframe(8'h02, PT, 256'h0), 8, 1'b0);
        check("midrst_keep_err", 256'(err), 256'(1));

        repeat (40) @(negedge clk);
        check("start_queue_empty", 256'(exp_start_q.size()), 256'(0));
        check("result_queue_empty", 256'(exp_q.size()), 256'(0));
        check("k192_no_start", 256'(start192), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
